// File: rtl/connect8_pkg.sv
// Shared tray-controller types, sizes and slot helpers.
// Used by tray_controller and, when TRAY_ROTATE_EN is defined, mask_rotate4.
package connect8_pkg;

    localparam int unsigned SLOT_CNT = 3;
    localparam int unsigned MASK_W   = 16;

    typedef enum logic [2:0] {
        REFILL,
        LOAD,
        SETTLE,
        SELECT,
        PLACE,
        OVER
    } tray_state_e;

    function automatic logic [SLOT_CNT-1:0] slot_onehot(input logic [1:0] slot);
        logic [SLOT_CNT-1:0] oh;
        case (slot)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Next unused slot after 'slot', wrapping 2 -> 0; stays put if none other is free.
    function automatic logic [1:0] next_unused(input logic [1:0] slot,
                                               input logic [SLOT_CNT-1:0] used);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        cand  = slot;
        pick  = slot;
        found = 1'b0;
        for (int unsigned k = 0; k < SLOT_CNT - 1; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!found && !used[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] lowest_unused(input logic [SLOT_CNT-1:0] used);
        logic [1:0] pick;
        if (!used[0])      pick = 2'd0;
        else if (!used[1]) pick = 2'd1;
        else               pick = 2'd2;
        return pick;
    endfunction

endpackage

// File: rtl/mask_rotate4.sv
// 90-degree clockwise rotation of a 4x4 row-major mask (MSB = top-left).
// Only compiled in when TRAY_ROTATE_EN is defined.
`ifdef TRAY_ROTATE_EN
module mask_rotate4
    import connect8_pkg::*;
(
    input  logic [MASK_W-1:0] mask_i,
    output logic [MASK_W-1:0] mask_o
);

    // new[r][c] = old[3-c][r], with cell (r,c) stored at bit 15-(4r+c)
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign mask_o[15-(4*r+c)] = mask_i[15-(4*(3-c)+r)];
        end
    end

endmodule
`endif

// File: rtl/tray_controller.sv
// Three-slot piece tray: refill from generator, player selection, placement handshake.
// Optional feature: define TRAY_ROTATE_EN to enable btn_rotate (via mask_rotate4).
module tray_controller
    import connect8_pkg::*;
#(
    parameter int unsigned FIT_SETTLE = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [63:0]         block1,
    input  logic [63:0]         block2,
    input  logic [63:0]         block3,
    output logic                generate_new,
    input  logic                btn_next,
    input  logic                btn_rotate,
    input  logic                btn_place,
    input  logic [SLOT_CNT-1:0] fits,
    output logic                place_valid,
    input  logic                place_ready,
    output logic [MASK_W-1:0]   place_shape,
    output logic [1:0]          place_slot,
    output logic [1:0]          sel_slot,
    output logic [SLOT_CNT-1:0] slot_used,
    output logic [MASK_W-1:0]   tray0,
    output logic [MASK_W-1:0]   tray1,
    output logic [MASK_W-1:0]   tray2,
    output logic                game_over
);

    localparam int unsigned SETTLE_LAST = (FIT_SETTLE == 0) ? 0 : FIT_SETTLE - 1;
    localparam int unsigned CNT_W       = (SETTLE_LAST > 1) ? $clog2(SETTLE_LAST + 1) : 1;

    tray_state_e         state_q, state_d;
    logic                gen_q, gen_d;
    logic                pv_q, pv_d;
    logic [MASK_W-1:0]   shape_q, shape_d;
    logic [1:0]          pslot_q, pslot_d;
    logic [1:0]          sel_q, sel_d;
    logic [SLOT_CNT-1:0] used_q, used_d;
    logic [MASK_W-1:0]   tray_q [SLOT_CNT];
    logic [MASK_W-1:0]   tray_d [SLOT_CNT];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                over_q, over_d;

    logic [MASK_W-1:0]   cur_shape;
    logic                fits_sel;
    logic [143:0]        unused_blk_hi;

    assign unused_blk_hi = {block1[63:16], block2[63:16], block3[63:16]};

    always_comb begin
        case (sel_q)
            2'd1:    cur_shape = tray_q[1];
            2'd2:    cur_shape = tray_q[2];
            default: cur_shape = tray_q[0];
        endcase
    end

    assign fits_sel = |(fits & slot_onehot(sel_q));

`ifdef TRAY_ROTATE_EN
    logic [MASK_W-1:0] rot_shape;

    mask_rotate4 u_rot (
        .mask_i (cur_shape),
        .mask_o (rot_shape)
    );
`else
    logic unused_rotate;
    assign unused_rotate = btn_rotate;
`endif

    always_comb begin
        state_d = state_q;
        gen_d   = 1'b0;
        pv_d    = pv_q;
        shape_d = shape_q;
        pslot_d = pslot_q;
        sel_d   = sel_q;
        used_d  = used_q;
        tray_d  = tray_q;
        cnt_d   = cnt_q;
        over_d  = over_q;

        case (state_q)
            // Entered with gen_q=0 after reset (pulse next cycle) or gen_q=1 from PLACE.
            REFILL: begin
                if (gen_q) state_d = LOAD;
                else       gen_d   = 1'b1;
            end
            LOAD: begin
                tray_d[0] = block1[MASK_W-1:0];
                tray_d[1] = block2[MASK_W-1:0];
                tray_d[2] = block3[MASK_W-1:0];
                used_d    = '0;
                sel_d     = '0;
                cnt_d     = '0;
                state_d   = SETTLE;
            end
            SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_LAST)) begin
                    if ((fits & ~used_q) == '0) begin
                        state_d = OVER;
                        over_d  = 1'b1;
                    end else begin
                        state_d = SELECT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SELECT: begin
                if (btn_place) begin
                    if (fits_sel) begin
                        state_d = PLACE;
                        pv_d    = 1'b1;
                        shape_d = cur_shape;
                        pslot_d = sel_q;
                    end
                end
`ifdef TRAY_ROTATE_EN
                else if (btn_rotate) begin
                    case (sel_q)
                        2'd1:    tray_d[1] = rot_shape;
                        2'd2:    tray_d[2] = rot_shape;
                        default: tray_d[0] = rot_shape;
                    endcase
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
`endif
                else if (btn_next) begin
                    sel_d = next_unused(sel_q, used_q);
                end
            end
            PLACE: begin
                if (place_ready) begin
                    used_d = used_q | slot_onehot(sel_q);
                    pv_d   = 1'b0;
                    if (&used_d) begin
                        state_d = REFILL;
                        gen_d   = 1'b1;
                    end else begin
                        sel_d   = lowest_unused(used_d);
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
            end
            OVER: ;
            default: state_d = REFILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= REFILL;
            gen_q   <= 1'b0;
            pv_q    <= 1'b0;
            shape_q <= '0;
            pslot_q <= '0;
            sel_q   <= '0;
            used_q  <= '0;
            tray_q  <= '{default: '0};
            cnt_q   <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            pv_q    <= pv_d;
            shape_q <= shape_d;
            pslot_q <= pslot_d;
            sel_q   <= sel_d;
            used_q  <= used_d;
            tray_q  <= tray_d;
            cnt_q   <= cnt_d;
            over_q  <= over_d;
        end
    end

    assign generate_new = gen_q;
    assign place_valid  = pv_q;
    assign place_shape  = shape_q;
    assign place_slot   = pslot_q;
    assign sel_slot     = sel_q;
    assign slot_used    = used_q;
    assign tray0        = tray_q[0];
    assign tray1        = tray_q[1];
    assign tray2        = tray_q[2];
    assign game_over    = over_q;

endmodule

// File: tb/tb_tray_controller.sv
// Self-checking bench for tray_controller: directed table, corner sequences, random vs model.
// Rotation expectations follow TRAY_ROTATE_EN when it is defined.
module tb_tray_controller;

    localparam int unsigned FIT_SETTLE = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] block1 = '0, block2 = '0, block3 = '0;
    logic        generate_new;
    logic        btn_next = 1'b0, btn_rotate = 1'b0, btn_place = 1'b0;
    logic [2:0]  fits = 3'b111;
    logic        place_valid;
    logic        place_ready = 1'b0;
    logic [15:0] place_shape;
    logic [1:0]  place_slot;
    logic [1:0]  sel_slot;
    logic [2:0]  slot_used;
    logic [15:0] tray0, tray1, tray2;
    logic        game_over;

    tray_controller #(.FIT_SETTLE(FIT_SETTLE)) dut (
        .clk(clk), .reset_n(reset_n),
        .block1(block1), .block2(block2), .block3(block3),
        .generate_new(generate_new),
        .btn_next(btn_next), .btn_rotate(btn_rotate), .btn_place(btn_place),
        .fits(fits),
        .place_valid(place_valid), .place_ready(place_ready),
        .place_shape(place_shape), .place_slot(place_slot),
        .sel_slot(sel_slot), .slot_used(slot_used),
        .tray0(tray0), .tray1(tray1), .tray2(tray2),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Generator: shape sets drawn from a fixed pool, advancing once per generate_new.
    logic [15:0] pool [8] = '{16'h0F00, 16'h0CC0, 16'h1111, 16'h8888,
                              16'hF000, 16'h0660, 16'h4E00, 16'h000F};
    int gen_cnt = 0;

    function automatic logic [15:0] pool_shape(input int n, input int j);
        if (n == 0) return 16'h0000;
        return pool[(3 * (n - 1) + j) % 8];
    endfunction

    task automatic set_blocks();
        block1 = {48'hDEAD_BEEF_5A5A, pool_shape(gen_cnt, 0)};
        block2 = {48'hC0DE_F00D_A5A5, pool_shape(gen_cnt, 1)};
        block3 = {48'h1234_5678_9ABC, pool_shape(gen_cnt, 2)};
    endtask

    // Reference model: a queue of scheduled per-cycle actions while the tray is busy;
    // an empty queue means the player is either selecting or has a request pending.
    typedef enum {A_GEN_ON, A_GEN_OFF, A_LOAD, A_WAIT, A_CHECK} act_e;
    act_e        sched [$];
    logic        m_gen, m_pv, m_over;
    logic [15:0] m_shape;
    logic [1:0]  m_pslot, m_sel;
    logic [2:0]  m_used;
    logic [15:0] m_tray [3];

    task automatic push_settle();
        int s;
        s = (FIT_SETTLE == 0) ? 1 : int'(FIT_SETTLE);
        for (int i = 0; i < s - 1; i++) sched.push_back(A_WAIT);
        sched.push_back(A_CHECK);
    endtask

    task automatic model_reset();
        sched.delete();
        sched.push_back(A_GEN_ON);
        sched.push_back(A_GEN_OFF);
        sched.push_back(A_LOAD);
        push_settle();
        m_gen = 0; m_pv = 0; m_over = 0; m_shape = '0; m_pslot = '0;
        m_sel = '0; m_used = '0;
        for (int i = 0; i < 3; i++) m_tray[i] = '0;
    endtask

`ifdef TRAY_ROTATE_EN
    function automatic logic [15:0] rot_ref(input logic [15:0] m);
        logic [15:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[15 - (4 * r + c)] = m[15 - (4 * (3 - c) + r)];
        return o;
    endfunction
`endif

    task automatic model_step();
        act_e a;
        int   s;
        m_gen = 1'b0;
        if (m_over) return;
        if (sched.size() != 0) begin
            a = sched.pop_front();
            case (a)
                A_GEN_ON: m_gen = 1'b1;
                A_LOAD: begin
                    m_tray[0] = block1[15:0];
                    m_tray[1] = block2[15:0];
                    m_tray[2] = block3[15:0];
                    m_used = '0;
                    m_sel  = '0;
                end
                A_CHECK: if ((fits & ~m_used) == 3'b000) m_over = 1'b1;
                default: ;
            endcase
        end else if (m_pv) begin
            if (place_ready) begin
                m_used[m_sel] = 1'b1;
                m_pv = 1'b0;
                if (m_used == 3'b111) begin
                    m_gen = 1'b1;
                    sched.push_back(A_GEN_OFF);
                    sched.push_back(A_LOAD);
                    push_settle();
                end else begin
                    for (int i = 2; i >= 0; i--) if (!m_used[i]) m_sel = 2'(i);
                    push_settle();
                end
            end
        end else if (btn_place) begin
            if (fits[m_sel]) begin
                m_pv = 1'b1;
                m_shape = m_tray[m_sel];
                m_pslot = m_sel;
            end
        end
`ifdef TRAY_ROTATE_EN
        else if (btn_rotate) begin
            m_tray[m_sel] = rot_ref(m_tray[m_sel]);
            push_settle();
        end
`endif
        else if (btn_next) begin
            s = int'(m_sel);
            for (int k = 2; k >= 1; k--) if (!m_used[(s + k) % 3]) m_sel = 2'((s + k) % 3);
        end
    endtask

    function automatic void check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void compare_all(input string name);
        check(name,
              {generate_new, place_valid, place_shape, place_slot, sel_slot, slot_used,
               tray0, tray1, tray2, game_over},
              {m_gen, m_pv, m_shape, m_pslot, m_sel, m_used,
               m_tray[0], m_tray[1], m_tray[2], m_over});
    endfunction

    // One clock: model advances on the pre-edge inputs, outputs compared #1 after the edge.
    task automatic tick();
        logic g;
        g = generate_new;
        if (reset_n) model_step();
        @(posedge clk);
        #1;
        if (g && reset_n) begin
            gen_cnt++;
            set_blocks();
        end
        compare_all("cycle");
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        gen_cnt = 0;
        set_blocks();
        #1;
        check("rst_async_pv", 80'(place_valid), 80'(0));
        compare_all("reset_state");
        @(posedge clk);
        #1;
        compare_all("reset_hold");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        logic nx, rt, pl;
        logic [2:0] f;
        logic rdy;
        logic e_pv;
        logic [15:0] e_shape;
        logic chk_shape;
        logic [1:0] e_slot;
        logic [2:0] e_used;
        logic [1:0] e_sel;
        logic e_gen;
    } vec_t;

    vec_t tbl [27];

    initial begin
        tbl[0]  = '{0,0,1,3'b111,0, 1,16'h0F00,1,2'd0,3'b000,2'd0,0};
        tbl[1]  = '{0,0,0,3'b111,0, 1,16'h0F00,1,2'd0,3'b000,2'd0,0};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = '{0,0,0,3'b111,1, 0,16'h0000,0,2'd0,3'b001,2'd1,0};
        tbl[5]  = '{0,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b001,2'd1,0};
        tbl[6]  = tbl[5];
        tbl[7]  = '{0,0,1,3'b111,0, 1,16'h0CC0,1,2'd1,3'b001,2'd1,0};
        tbl[8]  = '{0,0,0,3'b111,1, 0,16'h0000,0,2'd0,3'b011,2'd2,0};
        tbl[9]  = '{0,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b011,2'd2,0};
        tbl[10] = tbl[9];
        tbl[11] = '{0,0,1,3'b111,0, 1,16'h1111,1,2'd2,3'b011,2'd2,0};
        tbl[12] = '{0,0,0,3'b111,1, 0,16'h0000,0,2'd0,3'b111,2'd2,1};
        tbl[13] = '{0,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b111,2'd2,0};
        tbl[14] = '{0,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b000,2'd0,0};
        tbl[15] = tbl[14];
        tbl[16] = tbl[14];
        tbl[17] = '{1,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b000,2'd1,0};
        tbl[18] = '{1,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b000,2'd2,0};
        tbl[19] = '{1,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b000,2'd0,0};
        tbl[20] = '{1,0,1,3'b111,0, 1,16'h8888,1,2'd0,3'b000,2'd0,0};
        tbl[21] = '{0,0,0,3'b111,1, 0,16'h0000,0,2'd0,3'b001,2'd1,0};
        tbl[22] = '{0,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b001,2'd1,0};
        tbl[23] = tbl[22];
        tbl[24] = '{1,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b001,2'd2,0};
        tbl[25] = '{1,0,0,3'b111,0, 0,16'h0000,0,2'd0,3'b001,2'd1,0};
        tbl[26] = '{0,0,1,3'b101,0, 0,16'h0000,0,2'd0,3'b001,2'd1,0};

        // Reset, refill pulse timing and first load
        set_blocks();
        #3;
        do_reset();
        check("refill_cycle0_gen", 80'(generate_new), 80'(0));
        tick();
        check("gen_pulse_cycle1", 80'(generate_new), 80'(1));
        tick();
        check("gen_pulse_ends", 80'(generate_new), 80'(0));
        tick();
        check("load_tray0", 80'(tray0), 80'(16'h0F00));
        check("load_tray1", 80'(tray1), 80'(16'h0CC0));
        check("load_tray2", 80'(tray2), 80'(16'h1111));
        idle(2);

        // Directed table: delayed handshake, full refill, next wrap, priority, unfit place
        for (int i = 0; i < 27; i++) begin
            btn_next = tbl[i].nx; btn_rotate = tbl[i].rt; btn_place = tbl[i].pl;
            fits = tbl[i].f; place_ready = tbl[i].rdy;
            tick();
            btn_next = 0; btn_rotate = 0; btn_place = 0; place_ready = 0;
            check($sformatf("row%0d_pv", i), 80'(place_valid), 80'(tbl[i].e_pv));
            if (tbl[i].chk_shape)
                check($sformatf("row%0d_shape", i), 80'(place_shape), 80'(tbl[i].e_shape));
            if (tbl[i].e_pv)
                check($sformatf("row%0d_slot", i), 80'(place_slot), 80'(tbl[i].e_slot));
            check($sformatf("row%0d_used", i), 80'(slot_used), 80'(tbl[i].e_used));
            check($sformatf("row%0d_sel", i), 80'(sel_slot), 80'(tbl[i].e_sel));
            check($sformatf("row%0d_gen", i), 80'(generate_new), 80'(tbl[i].e_gen));
        end
        fits = 3'b111;

        // Game over: only the used slot fits
        do_reset();
        idle(5);
        btn_next = 1; tick(); btn_next = 0;
        btn_place = 1; tick(); btn_place = 0;
        place_ready = 1; tick(); place_ready = 0;
        check("go_used", 80'(slot_used), 80'(3'b010));
        fits = 3'b010;
        idle(2);
        check("go_set", 80'(game_over), 80'(1));
        for (int i = 0; i < 8; i++) begin
            btn_next = 1'($urandom_range(0, 1));
            btn_rotate = 1'($urandom_range(0, 1));
            btn_place = 1'($urandom_range(0, 1));
            place_ready = 1'($urandom_range(0, 1));
            fits = 3'($urandom_range(0, 7));
            tick();
            check("go_sticky", 80'(game_over), 80'(1));
            check("go_no_gen", 80'(generate_new), 80'(0));
        end
        btn_next = 0; btn_rotate = 0; btn_place = 0; place_ready = 0; fits = 3'b111;

        // Reset in the middle of a pending request
        do_reset();
        idle(5);
        btn_place = 1; tick(); btn_place = 0;
        tick();
        check("mid_place_pv", 80'(place_valid), 80'(1));
        do_reset();
        check("restart_cycle0_gen", 80'(generate_new), 80'(0));
        tick();
        check("restart_refill_gen", 80'(generate_new), 80'(1));
        idle(4);

        // Rotate, then a place request on a non-fitting slot
        do_reset();
        idle(5);
        btn_rotate = 1; tick(); btn_rotate = 0;
`ifdef TRAY_ROTATE_EN
        check("rotate_tray0", 80'(tray0), 80'(16'h2222));
`else
        check("rotate_ignored", 80'(tray0), 80'(16'h0F00));
`endif
        idle(2);
        fits = 3'b110;
        btn_place = 1; tick(); btn_place = 0;
        check("place_unfit_pv", 80'(place_valid), 80'(0));
        tick();
        check("place_unfit_pv2", 80'(place_valid), 80'(0));
        fits = 3'b111;

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if ((m_over && $urandom_range(0, 5) == 0) || $urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                fits = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
                btn_next = ($urandom_range(0, 3) == 0);
                btn_rotate = ($urandom_range(0, 5) == 0);
                btn_place = ($urandom_range(0, 3) == 0);
                place_ready = ($urandom_range(0, 2) == 0);
                tick();
            end
        end
        btn_next = 0; btn_rotate = 0; btn_place = 0; place_ready = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
